// File: rtl/operand_fwd_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | operand_fwd_unit : multi-source operand bypass with load-use stall.      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module operand_fwd_unit #(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int NUM_SRC    = 2,
   parameter int HIST_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC*REG_AW-1:0] i_src_addr,
   input  logic [NUM_SRC-1:0]        i_src_used,
   input  logic [NUM_SRC*DATA_W-1:0] i_src_rf_data,
   input  logic                      i_ex_wen,
   input  logic [REG_AW-1:0]         i_ex_waddr,
   input  logic [DATA_W-1:0]         i_ex_wdata,
   input  logic                      i_ex_is_load,
   input  logic                      i_mem_wen,
   input  logic [REG_AW-1:0]         i_mem_waddr,
   input  logic [DATA_W-1:0]         i_mem_wdata,
   input  logic                      i_mem_data_ready,
   input  logic                      i_wb_wen,
   input  logic [REG_AW-1:0]         i_wb_waddr,
   input  logic [DATA_W-1:0]         i_wb_wdata,
   input  logic                      i_flush,
   output logic [NUM_SRC*DATA_W-1:0] o_src_data,
   output logic [NUM_SRC*3-1:0]      o_fwd_sel,
   output logic                      o_stall_req,
   output logic [CNT_W-1:0]          o_stall_cnt
);

   localparam logic [2:0]       c_SEL_RF   = 3'd0;
   localparam logic [2:0]       c_SEL_EX   = 3'd1;
   localparam logic [2:0]       c_SEL_MEM  = 3'd2;
   localparam logic [2:0]       c_SEL_WB   = 3'd3;
   localparam logic [2:0]       c_SEL_HIST = 3'd4;
   localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_stall_cnt;
   logic [HIST_DEPTH-1:0]  r_hist_vld;
   logic [REG_AW-1:0]      r_hist_addr [HIST_DEPTH];
   logic [DATA_W-1:0]      r_hist_data [HIST_DEPTH];

   logic [HIST_DEPTH-1:0]  w_hist_vld;
   logic [NUM_SRC-1:0]     w_haz;
   logic                   w_push;

   // History reads as empty while reset is asserted.
   assign w_hist_vld = rst ? '0 : r_hist_vld;
   assign w_push     = i_wb_wen && (i_wb_waddr != '0);

   generate
      for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
         logic [REG_AW-1:0] w_addr;
         logic [DATA_W-1:0] w_rf;
         logic              w_hist_hit;
         logic [DATA_W-1:0] w_hist_dat;
         logic [DATA_W-1:0] w_data;
         logic [2:0]        w_sel;
         logic              w_haz_i;

         assign w_addr = i_src_addr[i*REG_AW +: REG_AW];
         assign w_rf   = i_src_rf_data[i*DATA_W +: DATA_W];

         // Scan oldest to newest so the newest matching entry wins.
         always_comb begin
            w_hist_hit = 1'b0;
            w_hist_dat = '0;
            for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
               if (w_hist_vld[k] && (r_hist_addr[k] == w_addr)) begin
                  w_hist_hit = 1'b1;
                  w_hist_dat = r_hist_data[k];
               end
            end
         end

         always_comb begin
            w_data  = w_rf;
            w_sel   = c_SEL_RF;
            w_haz_i = 1'b0;
            if (i_src_used[i] && (w_addr != '0)) begin
               if (i_ex_wen && (i_ex_waddr == w_addr)) begin
                  w_data  = i_ex_wdata;
                  w_sel   = c_SEL_EX;
                  w_haz_i = i_ex_is_load;
               end else if (i_mem_wen && (i_mem_waddr == w_addr)) begin
                  w_data  = i_mem_wdata;
                  w_sel   = c_SEL_MEM;
                  w_haz_i = ~i_mem_data_ready;
               end else if (i_wb_wen && (i_wb_waddr == w_addr)) begin
                  w_data  = i_wb_wdata;
                  w_sel   = c_SEL_WB;
               end else if (w_hist_hit) begin
                  w_data  = w_hist_dat;
                  w_sel   = c_SEL_HIST;
               end
            end
         end

         assign o_src_data[i*DATA_W +: DATA_W] = w_data;
         assign o_fwd_sel[i*3 +: 3]            = w_sel;
         assign w_haz[i]                       = w_haz_i;
      end
   endgenerate

   assign o_stall_req = (|w_haz) & ~i_flush;
   assign o_stall_cnt = r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hist_vld <= '0;
      end else if (w_push) begin
         r_hist_vld[0]  <= 1'b1;
         r_hist_addr[0] <= i_wb_waddr;
         r_hist_data[0] <= i_wb_wdata;
         for (int k = 1; k < HIST_DEPTH; k++) begin
            r_hist_vld[k]  <= r_hist_vld[k-1];
            r_hist_addr[k] <= r_hist_addr[k-1];
            r_hist_data[k] <= r_hist_data[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_stall_cnt <= '0;
      end else begin
         if (o_stall_req && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         case (r_state)
            ST_IDLE:  if (o_stall_req) r_state <= ST_STALL;
            ST_STALL: if (!o_stall_req || i_flush) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/operand_fwd_unit.md
Name: operand_fwd_unit

Overview:
- Parametrised operand bypass network for the ID/EX boundary.
- Selects each source operand from, in priority order: the EX, MEM and WB producers, a small history buffer of recently committed writebacks, or the register-file read data.
- Detects load-use hazards and raises a stall request.
- Runs a stall-tracking FSM with a saturating stall-cycle performance counter.
- Replaces the fixed two-operand, single-source forwarding mux in front of the ALU.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands forwarded in parallel.
- HIST_DEPTH, 2, committed-write history entries (>=1); covers register files without write-through.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- src_addr  input  NUM_SRC*REG_AW  source register numbers; source i in bits [i*REG_AW +: REG_AW].
- src_used  input  NUM_SRC  source i is actually read by the ID instruction.
- src_rf_data  input  NUM_SRC*DATA_W  register-file read data per source.
- ex_wen / ex_waddr / ex_wdata  input  1 / REG_AW / DATA_W  EX-stage producer.
- ex_is_load  input  1  EX instruction is a load; its result is not available.
- mem_wen / mem_waddr / mem_wdata  input  1 / REG_AW / DATA_W  MEM-stage producer.
- mem_data_ready  input  1  MEM result is valid; 0 for a load still awaiting data.
- wb_wen / wb_waddr / wb_wdata  input  1 / REG_AW / DATA_W  WB producer; wb_wen=1 means the write commits this cycle.
- flush  input  1  pipeline flush (branch/exception).
- src_data  output  NUM_SRC*DATA_W  forwarded operand per source.
- fwd_sel  output  NUM_SRC*3  per-source select: 0=RF, 1=EX, 2=MEM, 3=WB, 4=HIST.
- stall_req  output  1  hold PC/IF/ID and insert a bubble into EX.
- stall_cnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Per source i, all combinational:
  - Forwarding applies only if addr!=0 and src_used[i]=1.
  - Register 0 is never forwarded: src_data=src_rf_data, fwd_sel=0.
- Match priority:
  1. EX match with ex_wen=1.
  2. MEM match with mem_wen=1.
  3. WB match with wb_wen=1.
  4. History match, newest valid entry first.
  5. Otherwise RF.
- Data selected per match:
  - EX match with ex_is_load=0: ex_wdata, sel 1.
  - EX match with ex_is_load=1: hazard; src_data is don't-care, sel 1.
  - MEM match with mem_data_ready=1: mem_wdata, sel 2.
  - MEM match with mem_data_ready=0: hazard, sel 2.
  - WB match: wb_wdata, sel 3.
  - History match: entry data, sel 4.
- A matched-but-not-ready producer blocks lower-priority matches; the stale value is never forwarded.
- hazard = OR of per-source hazards. stall_req = hazard & ~flush, combinational, same cycle.
- History buffer: shift register of {valid, addr, data}, depth HIST_DEPTH.
  - On clk, if wb_wen=1 and wb_waddr!=0: entry0 <= WB write; entry k <= entry k-1; oldest entry is dropped.
  - Otherwise the buffer holds.
  - Writes to register 0 are not pushed.
  - flush does not affect the history; committed writes are architectural.
  - Duplicate addresses may coexist; the newest wins.
- Stall FSM, states IDLE and STALL:
  - IDLE -> STALL when stall_req=1.
  - STALL stays while stall_req=1.
  - STALL -> IDLE when stall_req=0 or flush=1.
  - flush forces IDLE next cycle regardless of hazard.
- stall_cnt increments by 1 on every clk where stall_req=1 and saturates at 2^CNT_W-1, with no wrap.
- Reset (rst=1 at clk edge):
  - All history valid bits <= 0, FSM <= IDLE, stall_cnt <= 0.
  - Reset dominates a simultaneous wb_wen push.
  - While rst=1, outputs remain combinational on current inputs, with history treated as empty.
- Simultaneous events:
  - WB push and a history lookup in the same cycle: the lookup uses the pre-push contents; the same-cycle WB data is covered by the WB match.
  - Every source is resolved independently; both sources may hazard on the same producer.

Test Plan:
- EX forward: ex_wen=1, ex_waddr=8, ex_wdata=0x11111111, src0 addr=8 used, rf=0xDEAD0000 -> src0_data=0x11111111, fwd_sel0=1, stall_req=0.
- Priority: EX, MEM and WB all write r9 with 0xA, 0xB, 0xC; src1 addr=9 -> 0xA, sel 1. Drop ex_wen -> 0xB, sel 2. Drop mem_wen -> 0xC, sel 3.
- Load-use:
  - ex_is_load=1, ex_waddr=4, src0 addr=4 -> stall_req=1, FSM STALL next cycle, stall_cnt increments.
  - Next cycle EX bubble, MEM match with mem_data_ready=0 -> stall_req=1 again.
  - Raise mem_data_ready with mem_wdata=0x55 -> 0x55, stall_req=0, FSM returns to IDLE.
- History:
  - Commit WB r3=0x100 then r3=0x200 on consecutive cycles, then r5=0x300.
  - src0 addr=3 with no pipeline matches -> 0x200, sel 4.
  - After HIST_DEPTH further commits to other registers -> src0 falls back to rf, sel 0.
- r0 / unused / flush:
  - ex_wen=1, ex_waddr=0, src addr=0 -> rf data, sel 0, no stall.
  - ex_is_load hazard with src_used=0 -> no stall.
  - Hazard with flush=1 -> stall_req=0, FSM IDLE.
- Counter/reset:
  - Force a hazard for 2^CNT_W+5 cycles -> stall_cnt saturates at all-ones.
  - rst=1 together with wb_wen=1 -> stall_cnt=0 and history empty, so a lookup of that register returns rf data.
